// File: rtl/dvi_timing_controller.sv
// DVI raster timing generator and pixel sequencer for three TMDS encoders.
// Stage 0 holds the raster counters and the per-frame enable.
// Stage 1 issues the pixel request and coordinates to the line source.
// Stage 2 drives aligned data, data-enable and control to the encoders.
module dvi_timing_controller #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        pixel_req,
    input  logic [23:0] pixel_rgb,
    input  logic        pixel_valid,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        frame_start,
    output logic        line_start,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [1:0]  ctrl_blue,
    output logic [1:0]  ctrl_rg,
    output logic        vblank,
    output logic        underflow,
    input  logic        underflow_clr
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    // Region bounds are 12 bits wide so a bound equal to 2048 still compares correctly.
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_raster_too_large
        $error("dvi_timing_controller: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    function automatic logic sync_level(input logic in_sync, input logic pol);
        return ~(in_sync ^ pol);
    endfunction

    // ---- stage 0: raster counters ----
    logic [10:0] h_cnt_p0;
    logic [10:0] v_cnt_p0;
    logic        frame_en_p0;
    logic [11:0] h_ext_p0;
    logic [11:0] v_ext_p0;
    logic        origin_p0;
    logic        frame_en_now_p0;
    logic        active_p0;
    logic        sync_h_p0;
    logic        sync_v_p0;
    logic        vblank_p0;
    logic        line_start_p0;

    assign h_ext_p0        = {1'b0, h_cnt_p0};
    assign v_ext_p0        = {1'b0, v_cnt_p0};
    assign origin_p0       = (h_cnt_p0 == 11'd0) && (v_cnt_p0 == 11'd0);
    // At the origin the freshly sampled enable governs the frame's first pixel too.
    assign frame_en_now_p0 = origin_p0 ? enable : frame_en_p0;
    assign active_p0       = (h_ext_p0 < H_ACT_END) && (v_ext_p0 < V_ACT_END);
    assign sync_h_p0       = (h_ext_p0 >= H_SYNC_BEG) && (h_ext_p0 < H_SYNC_END);
    assign sync_v_p0       = (v_ext_p0 >= V_SYNC_BEG) && (v_ext_p0 < V_SYNC_END);
    assign vblank_p0       = (v_ext_p0 >= V_ACT_END);
    assign line_start_p0   = (h_cnt_p0 == 11'd0) && !vblank_p0;

    // Free-running raster position; enable is latched once per frame at the origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_p0    <= 11'd0;
            v_cnt_p0    <= 11'd0;
            frame_en_p0 <= 1'b0;
        end else begin
            if (origin_p0) frame_en_p0 <= enable;
            if (h_cnt_p0 == H_LAST) begin
                h_cnt_p0 <= 11'd0;
                v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 11'd0 : v_cnt_p0 + 11'd1;
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 11'd1;
            end
        end
    end

    // ---- stage 1: pixel request and raster decode ----
    logic        req_p1;
    logic [10:0] x_p1;
    logic [10:0] y_p1;
    logic        frame_start_p1;
    logic        line_start_p1;
    logic        active_p1;
    logic        sync_h_p1;
    logic        sync_v_p1;
    logic        vblank_p1;

    // Register the decoded position; the request goes out with its coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_p1         <= 1'b0;
            x_p1           <= 11'd0;
            y_p1           <= 11'd0;
            frame_start_p1 <= 1'b0;
            line_start_p1  <= 1'b0;
            active_p1      <= 1'b0;
            sync_h_p1      <= 1'b0;
            sync_v_p1      <= 1'b0;
            vblank_p1      <= 1'b0;
        end else begin
            req_p1         <= active_p0 && frame_en_now_p0;
            x_p1           <= h_cnt_p0;
            y_p1           <= v_cnt_p0;
            frame_start_p1 <= origin_p0;
            line_start_p1  <= line_start_p0;
            active_p1      <= active_p0;
            sync_h_p1      <= sync_h_p0;
            sync_v_p1      <= sync_v_p0;
            vblank_p1      <= vblank_p0;
        end
    end

    // ---- stage 2: encoder-facing outputs ----
    logic        de_p2;
    logic        hsync_p2;
    logic        vsync_p2;
    logic        vblank_p2;
    logic [23:0] rgb_p2;
    logic        underflow_p2;

    // Capture source data against the request; a missing pixel is sent black and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_p2        <= 1'b0;
            hsync_p2     <= ~HSYNC_POL;
            vsync_p2     <= ~VSYNC_POL;
            vblank_p2    <= 1'b0;
            rgb_p2       <= 24'd0;
            underflow_p2 <= 1'b0;
        end else begin
            de_p2     <= active_p1;
            hsync_p2  <= sync_level(sync_h_p1, HSYNC_POL);
            vsync_p2  <= sync_level(sync_v_p1, VSYNC_POL);
            vblank_p2 <= vblank_p1;
            rgb_p2    <= (req_p1 && pixel_valid) ? pixel_rgb : 24'd0;
            if (req_p1 && !pixel_valid) begin
                underflow_p2 <= 1'b1;
            end else if (underflow_clr) begin
                underflow_p2 <= 1'b0;
            end
        end
    end

    assign pixel_req   = req_p1;
    assign pixel_x     = x_p1;
    assign pixel_y     = y_p1;
    assign frame_start = frame_start_p1;
    assign line_start  = line_start_p1;
    assign de          = de_p2;
    assign hsync       = hsync_p2;
    assign vsync       = vsync_p2;
    assign vblank      = vblank_p2;
    assign red         = rgb_p2[23:16];
    assign green       = rgb_p2[15:8];
    assign blue        = rgb_p2[7:0];
    assign ctrl_blue   = {vsync_p2, hsync_p2};
    assign ctrl_rg     = 2'b00;
    assign underflow   = underflow_p2;

endmodule
